// File: rtl/skinny_sbox8_pini1_seq.sv
// skinny_sbox8_pini1_seq: byte-serial sequencer feeding one shared masked SKINNY S-box over a two-share 128-bit state
module skinny_sbox8_pini1_seq #(
    parameter int SBOX_LAT = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_s0,
    input  logic [127:0] in_s1,
    input  logic         rnd_valid,
    output logic         rnd_ready,
    input  logic [7:0]   rnd,
    output logic [7:0]   sb_si0,
    output logic [7:0]   sb_si1,
    output logic [7:0]   sb_r,
    input  logic [7:0]   sb_bo0,
    input  logic [7:0]   sb_bo1,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_s0,
    output logic [127:0] out_s1,
    output logic         busy
);

    typedef enum logic [1:0] {IDLE, RND, EVAL, DONE} state_t;

    state_t       state_q, state_d;
    logic [127:0] st0_q, st1_q;
    logic [7:0]   sb_si0_q, sb_si1_q, sb_r_q;
    logic [3:0]   idx_q, lc_q;
    logic         lc_last;

    assign lc_last = lc_q == 4'(SBOX_LAT - 1);
    assign sb_si0  = sb_si0_q;
    assign sb_si1  = sb_si1_q;
    assign sb_r    = sb_r_q;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM next-state: a byte completes when the S-box has seen stable operands for SBOX_LAT cycles
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = RND;
            RND:     if (rnd_valid) state_d = EVAL;
            EVAL:    if (lc_last) state_d = (idx_q == 4'd15) ? DONE : RND;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs; the state is only exposed while it is being offered
    always_comb begin
        in_ready  = state_q == IDLE;
        rnd_ready = state_q == RND;
        out_valid = state_q == DONE;
        busy      = state_q != IDLE;
        out_s0    = out_valid ? st0_q : '0;
        out_s1    = out_valid ? st1_q : '0;
    end

    // Datapath: shares stay in separate registers; S-box operands and mask change together only on a mask handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st0_q    <= '0;
            st1_q    <= '0;
            sb_si0_q <= '0;
            sb_si1_q <= '0;
            sb_r_q   <= '0;
            idx_q    <= '0;
            lc_q     <= '0;
        end else begin
            if (state_q == IDLE && in_valid) begin
                st0_q <= in_s0;
                st1_q <= in_s1;
                idx_q <= '0;
            end
            if (state_q == RND && rnd_valid) begin
                sb_si0_q <= st0_q[7:0];
                sb_si1_q <= st1_q[7:0];
                sb_r_q   <= rnd;
                lc_q     <= '0;
            end
            if (state_q == EVAL) begin
                lc_q <= lc_q + 4'd1;
                if (lc_last) begin
                    st0_q <= {sb_bo0, st0_q[127:8]};
                    st1_q <= {sb_bo1, st1_q[127:8]};
                    idx_q <= idx_q + 4'd1;
                end
            end
        end
    end

endmodule
